data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_if.sv | 27 ++
 rtl/data_memory.sv | 116 +++++++++++
 tb/tb_data_memory.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// data_memory_if
// Word-wide request/response bus between a data cache (master) and the
// backing data memory (slave).
//   mem_read      : word read request, held until mem_busywait falls
//   mem_write     : word write request, held until mem_busywait falls
//   mem_address   : word index (byte address bits [7:2])
//   mem_writedata : write word, byte 0 in bits [7:0]
//   mem_readdata  : read word, byte 0 in bits [7:0]
//   mem_busywait  : high while an access is pending or in progress
interface data_memory_if;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/data_memory.sv
// data_memory
// 64 x 32-bit word memory with a fixed access latency, sitting behind a
// data cache. Each access takes LATENCY cycles in BUSY followed by one DONE
// cycle in which the read word is presented and mem_busywait is low.
//   clock : system clock, rising-edge
//   reset : synchronous, active-high; clears state, read register and all words
//   bus   : data_memory_if.slave request/response bus
// Optional build macro DATA_MEMORY_STATS_EN adds:
//   read_count  : saturating count of completed reads
//   write_count : saturating count of completed writes
module data_memory #(
  parameter int LATENCY = 5
) (
  input  logic              clock,
  input  logic              reset,
  data_memory_if.slave      bus
`ifdef DATA_MEMORY_STATS_EN
  ,
  output logic [15:0]       read_count,
  output logic [15:0]       write_count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  counter;
  logic        op_write;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] readdata_q;
  logic [31:0] words [64];
  logic        request;
  logic        finishing;

  assign request   = bus.mem_read | bus.mem_write;
  // The access happens on the BUSY edge where the countdown has reached zero.
  assign finishing = (state == BUSY) && (counter == 4'd0);

  assign bus.mem_readdata = readdata_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Busywait is combinational so the cache sees it in the same cycle it
  // raises a request; DONE drops it for exactly one cycle.
  always_comb begin
    next_state       = state;
    bus.mem_busywait = 1'b0;
    case (state)
      IDLE: begin
        bus.mem_busywait = request;
        if (request) next_state = BUSY;
      end
      BUSY: begin
        bus.mem_busywait = 1'b1;
        if (counter == 4'd0) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are latched at accept so the cache may change or drop
  // them during BUSY. A simultaneous read+write is taken as a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter    <= 4'd0;
      op_write   <= 1'b0;
      addr_q     <= 6'd0;
      wdata_q    <= 32'h0;
      readdata_q <= 32'h0;
      for (int i = 0; i < 64; i++) words[i] <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            op_write <= bus.mem_write;
            addr_q   <= bus.mem_address;
            wdata_q  <= bus.mem_writedata;
            counter  <= 4'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (counter == 4'd0) begin
            if (op_write) words[addr_q] <= wdata_q;
            else          readdata_q    <= words[addr_q];
          end else begin
            counter <= counter - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DATA_MEMORY_STATS_EN
  // Completed-access counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_count  <= 16'h0;
      write_count <= 16'h0;
    end else if (finishing) begin
      if (op_write) begin
        if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      end else begin
        if (read_count != 16'hFFFF) read_count <= read_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
// Directed self-checking bench for data_memory with LATENCY = 5.
module tb_data_memory;
  localparam int LAT = 5;

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;
  logic [31:0] rd;
  int   busy;

  data_memory_if bus ();

`ifdef DATA_MEMORY_STATS_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  data_memory #(.LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef DATA_MEMORY_STATS_EN
    ,
    .read_count  (read_count),
    .write_count (write_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts BUSY cycles after the accept edge, bounded; returns with the
  // bench parked at the negedge of the DONE cycle.
  task automatic wait_done(input string tag, output int cycles);
    logic seen_low;
    seen_low = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!bus.mem_busywait) begin
        seen_low = 1'b1;
        break;
      end
      cycles++;
    end
    check({tag, "_done_seen"}, {31'h0, seen_low}, 32'h1);
  endtask

  // Full single access: drive at negedge, expect busywait in the request
  // cycle, wait out BUSY, capture readdata in DONE, then release.
  task automatic access(input string tag, input logic rd_en, input logic wr_en,
                        input logic [5:0] a, input logic [31:0] d,
                        output logic [31:0] data, output int cycles);
    @(negedge clock);
    bus.mem_read      = rd_en;
    bus.mem_write     = wr_en;
    bus.mem_address   = a;
    bus.mem_writedata = d;
    #1;
    check({tag, "_req_busy"}, {31'h0, bus.mem_busywait}, 32'h1);
    @(posedge clock);
    wait_done(tag, cycles);
    data = bus.mem_readdata;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = 6'd0;
    bus.mem_writedata = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_busywait", {31'h0, bus.mem_busywait}, 32'h0);
    check("reset_readdata", bus.mem_readdata, 32'h0);

    // Read of a cleared word
    access("read3", 1'b1, 1'b0, 6'd3, 32'h0, rd, busy);
    check("read3_busy_cycles", busy, LAT);
    check("read3_data", rd, 32'h0);

    // Write then read back, neighbours untouched
    access("wr10", 1'b0, 1'b1, 6'd10, 32'hDEADBEEF, rd, busy);
    check("wr10_busy_cycles", busy, LAT);
    access("rd10", 1'b1, 1'b0, 6'd10, 32'h0, rd, busy);
    check("rd10_data", rd, 32'hDEADBEEF);
    access("rd9", 1'b1, 1'b0, 6'd9, 32'h0, rd, busy);
    check("rd9_data", rd, 32'h0);
    access("rd11", 1'b1, 1'b0, 6'd11, 32'h0, rd, busy);
    check("rd11_data", rd, 32'h0);

    // A write must leave the read register alone
    access("rd10b", 1'b1, 1'b0, 6'd10, 32'h0, rd, busy);
    access("wr5", 1'b0, 1'b1, 6'd5, 32'h11111111, rd, busy);
    check("wr5_readdata_held", rd, 32'hDEADBEEF);
    access("rd5", 1'b1, 1'b0, 6'd5, 32'h0, rd, busy);
    check("rd5_data", rd, 32'h11111111);

    // Read and write together behave as a write
    access("both20", 1'b1, 1'b1, 6'd20, 32'hCAFEF00D, rd, busy);
    check("both20_readdata_held", rd, 32'h11111111);
    access("rd20", 1'b1, 1'b0, 6'd20, 32'h0, rd, busy);
    check("rd20_data", rd, 32'hCAFEF00D);

    // Back-to-back reads with mem_read held through DONE
    @(negedge clock);
    bus.mem_read    = 1'b1;
    bus.mem_address = 6'd10;
    @(posedge clock);
    wait_done("b2b_first", busy);
    check("b2b_first_busy_cycles", busy, LAT);
    check("b2b_first_data", bus.mem_readdata, 32'hDEADBEEF);
    bus.mem_address = 6'd5;
    @(negedge clock);
    check("b2b_idle_busy", {31'h0, bus.mem_busywait}, 32'h1);
    @(posedge clock);
    wait_done("b2b_second", busy);
    check("b2b_second_busy_cycles", busy, LAT);
    check("b2b_second_data", bus.mem_readdata, 32'h11111111);
    bus.mem_read = 1'b0;

    // Address change and request drop during BUSY are ignored
    access("wr1", 1'b0, 1'b1, 6'd1, 32'h00000111, rd, busy);
    access("wr2", 1'b0, 1'b1, 6'd2, 32'h00000222, rd, busy);
    @(negedge clock);
    bus.mem_read    = 1'b1;
    bus.mem_address = 6'd1;
    @(posedge clock);
    @(negedge clock);
    bus.mem_address = 6'd2;
    bus.mem_read    = 1'b0;
    check("addrchg_busy_held", {31'h0, bus.mem_busywait}, 32'h1);
    wait_done("addrchg", busy);
    check("addrchg_busy_cycles", busy, LAT - 1);
    check("addrchg_data", bus.mem_readdata, 32'h00000111);

    // Reset in BUSY cycle 2 aborts the pending write
    @(negedge clock);
    bus.mem_write     = 1'b1;
    bus.mem_address   = 6'd63;
    bus.mem_writedata = 32'h12345678;
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    bus.mem_write = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busywait", {31'h0, bus.mem_busywait}, 32'h0);
    check("abort_readdata", bus.mem_readdata, 32'h0);
    access("rd63", 1'b1, 1'b0, 6'd63, 32'h0, rd, busy);
    check("rd63_data", rd, 32'h0);
    access("rd10_cleared", 1'b1, 1'b0, 6'd10, 32'h0, rd, busy);
    check("rd10_cleared_data", rd, 32'h0);

`ifdef DATA_MEMORY_STATS_EN
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("stats_reset_rd", {16'h0, read_count}, 32'h0);
    check("stats_reset_wr", {16'h0, write_count}, 32'h0);
    access("s_rd0", 1'b1, 1'b0, 6'd0, 32'h0, rd, busy);
    access("s_wr0", 1'b0, 1'b1, 6'd0, 32'h5, rd, busy);
    access("s_rd1", 1'b1, 1'b0, 6'd1, 32'h0, rd, busy);
    access("s_wr1", 1'b0, 1'b1, 6'd1, 32'h6, rd, busy);
    access("s_rd2", 1'b1, 1'b0, 6'd0, 32'h0, rd, busy);
    check("s_rd2_data", rd, 32'h5);
    check("stats_rd", {16'h0, read_count}, 32'd3);
    check("stats_wr", {16'h0, write_count}, 32'd2);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("stats_clr_rd", {16'h0, read_count}, 32'h0);
    check("stats_clr_wr", {16'h0, write_count}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
